// File: rtl/nios_avalon_st_rr_arbiter.sv
// nios_avalon_st_rr_arbiter: round-robin packet arbiter sharing one Avalon-ST FIFO among NUM_IN sources
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_data/      per-source Avalon-ST sink side; source i data is
//   in_sop/in_eop/in_ready in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_data/    muxed stream towards the FIFO write side
//   out_ready
//   fill_level             FIFO occupancy; no new grant at or above ALMOST_FULL
//   grant                  one-hot registered grant (zero when idle)
//   out_channel            encoded index of the granted source
//
// Build option: ST_ARB_PACKET_LOCK_EN
//   defined   - a grant is held until the eop beat transfers (packets never split)
//   undefined - the grant is released after every transferred beat, so beats interleave
module nios_avalon_st_rr_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int DATA_WIDTH  = 42,
  parameter int CH_WIDTH    = 2,
  parameter int FILL_WIDTH  = 5,
  parameter int ALMOST_FULL = 14
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_sop,
  input  logic [NUM_IN-1:0]            in_eop,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  input  logic [FILL_WIDTH-1:0]        fill_level,
  output logic [NUM_IN-1:0]            grant,
  output logic [CH_WIDTH-1:0]          out_channel
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state_q, state_d;
  logic [NUM_IN-1:0]     grant_q, grant_d;
  logic [CH_WIDTH-1:0]   chan_q, chan_d, last_q, last_d, pick;
  logic                  found, xfer, done;
  logic                  sop_unused;
  // Packet boundaries come from eop only; sop carries no arbitration meaning.
  assign sop_unused = ^in_sop;
  // Round-robin search starting just after the last source served.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++)
      for (int i = 0; i < NUM_IN; i++)
        if (!found && in_valid[i] && i == (int'(last_q) + k) % NUM_IN) begin
          found = 1'b1;
          pick  = CH_WIDTH'(i);
        end
  end
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (grant_q[i]) out_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign out_valid   = |(grant_q & in_valid);
  assign in_ready    = grant_q & {NUM_IN{out_ready}};
  assign grant       = grant_q;
  assign out_channel = chan_q;
  assign xfer        = out_valid && out_ready;
`ifdef ST_ARB_PACKET_LOCK_EN
  assign done = xfer && |(grant_q & in_eop);
`else
  assign done = xfer;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (state_q == IDLE && found && fill_level < FILL_WIDTH'(ALMOST_FULL)) begin
      state_d = BUSY;
      grant_d = NUM_IN'(1) << pick;
      chan_d  = pick;
    end else if (state_q == BUSY && done) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = chan_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      chan_q  <= '0;
      last_q  <= CH_WIDTH'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_nios_avalon_st_rr_arbiter.sv
// tb_nios_avalon_st_rr_arbiter: scoreboard bench for the round-robin Avalon-ST arbiter
module tb_nios_avalon_st_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 42;
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    in_valid, in_sop, in_eop, in_ready, grant;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic [4:0]      fill_level;
  logic [1:0]      out_channel;
  always #5 clk = ~clk;
  nios_avalon_st_rr_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fill_level(fill_level),
    .grant(grant), .out_channel(out_channel)
  );
  int            checks = 0, errors = 0, cyc = 0, pop_cyc = 0, mon_s;
  logic [DW-1:0] mon_d;
  logic [DW:0]   src_q[N][$];
  int            exp_src[$];
  logic [DW-1:0] exp_dat[$];
  logic [N-1:0]  took = '0;
  bit            rand_mode = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] beat(input int s, input int p, input int b);
    return DW'((s << 8) | (p << 4) | b);
  endfunction
  task automatic send(input int s, input int p, input int n);
    for (int b = 0; b < n; b++) src_q[s].push_back({b == n - 1, beat(s, p, b)});
  endtask
  task automatic expb(input int s, input int p, input int b);
    exp_src.push_back(s);
    exp_dat.push_back(beat(s, p, b));
  endtask
  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_src.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_src.size()), 0);
  endtask
  // Source models: present the head beat of each queue, pop it after it transferred.
  initial begin
    in_valid = '0; in_data = '0; in_sop = '0; in_eop = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (took[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (rand_mode) begin
          in_valid[i] = 1'($urandom);
          in_eop[i]   = 1'($urandom);
          in_sop[i]   = 1'($urandom);
          in_data[i*DW +: DW] = DW'({$urandom, $urandom});
        end else if (src_q[i].size() != 0) begin
          in_valid[i] = 1'b1;
          in_eop[i]   = src_q[i][0][DW];
          in_sop[i]   = src_q[i][0][3:0] == 4'd0;
          in_data[i*DW +: DW] = src_q[i][0][DW-1:0];
        end else begin
          in_valid[i] = 1'b0;
          in_eop[i]   = 1'b0;
          in_sop[i]   = 1'b0;
          in_data[i*DW +: DW] = '0;
        end
      end
    end
  end
  // Monitor: every beat accepted by the FIFO is popped from the scoreboard and compared.
  always @(negedge clk) begin
    took <= in_valid & in_ready;
    chk("grant_onehot0", 64'($onehot0(grant)), 1);
    if (grant == '0) begin
      chk("idle_out_valid", 64'(out_valid), 0);
      chk("idle_in_ready", 64'(in_ready), 0);
      chk("idle_out_data", 64'(out_data), 0);
    end
    if (out_valid && out_ready) begin
      if (exp_src.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none at cycle %0d", out_data, cyc);
      end else begin
        mon_s = exp_src.pop_front();
        mon_d = exp_dat.pop_front();
        chk("beat_data", 64'(out_data), 64'(mon_d));
        chk("beat_grant", 64'(grant), 64'(1) << mon_s);
        chk("beat_channel", 64'(out_channel), 64'(mon_s));
        pop_cyc = cyc;
      end
    end
  end
  initial begin
    int t0, n;
    int ord[4] = '{3, 0, 1, 2};
    out_ready = 1'b0;
    fill_level = '0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_channel", 64'(out_channel), 0);
      out_ready  = 1'($urandom);
      fill_level = 5'($urandom);
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    fill_level = '0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // First request after reset: one cycle of arbitration latency.
    send(2, 0, 1); expb(2, 0, 0); t0 = cyc;
    @(negedge clk);
    chk("arb_latency_grant", 64'(grant), 0);
    chk("arb_latency_valid", 64'(in_valid), 64'h4);
    wait_drain(20);
    chk("first_grant_cycle", 64'(pop_cyc - t0), 2);
    // Two 3-beat packets from sources 0 and 2.
    @(negedge clk);
    send(0, 1, 3); send(2, 1, 3);
`ifdef ST_ARB_PACKET_LOCK_EN
    for (int b = 0; b < 3; b++) expb(0, 1, b);
    for (int b = 0; b < 3; b++) expb(2, 1, b);
`else
    for (int b = 0; b < 3; b++) begin expb(0, 1, b); expb(2, 1, b); end
`endif
    wait_drain(40);
    // All sources with single-beat packets: rotation and 2-cycle grant cadence.
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) send(s, 2 + 2 * r, 1);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) expb(ord[k], 2 + 2 * r, 0);
    t0 = cyc;
    wait_drain(40);
    chk("rr_cadence", 64'(pop_cyc - t0), 16);
    // Throttle at the ALMOST_FULL boundary, then ignored mid-packet.
    @(negedge clk);
    fill_level = 5'd14;
    send(1, 5, 3);
    for (int b = 0; b < 3; b++) expb(1, 5, b);
    repeat (3) begin
      @(negedge clk);
      chk("throttle_hold", 64'(grant), 0);
    end
    fill_level = 5'd13;
    @(negedge clk);
    chk("throttle_release", 64'(grant), 64'h2);
    fill_level = 5'd15;
    repeat (4) @(posedge clk);
    #1;
`ifdef ST_ARB_PACKET_LOCK_EN
    chk("throttle_midpkt_left", 64'(exp_src.size()), 0);
`else
    chk("throttle_perbeat_left", 64'(exp_src.size()), 2);
`endif
    chk("throttle_after_grant", 64'(grant), 0);
    fill_level = '0;
    wait_drain(20);
    // Backpressure: three cycles of out_ready=0 after the first beat.
    @(negedge clk);
    send(3, 6, 4);
    for (int b = 0; b < 4; b++) expb(3, 6, b);
    n = 0;
    while (exp_src.size() > 3 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("stall_reached", 64'(n < 20), 1);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_count", 64'(exp_src.size()), 3);
`ifdef ST_ARB_PACKET_LOCK_EN
      chk("stall_out_valid", 64'(out_valid), 1);
`endif
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(30);
    // Two 4-beat packets from sources 0 and 1.
    @(negedge clk);
    send(0, 3, 4); send(1, 3, 4);
`ifdef ST_ARB_PACKET_LOCK_EN
    for (int b = 0; b < 4; b++) expb(0, 3, b);
    for (int b = 0; b < 4; b++) expb(1, 3, b);
`else
    for (int b = 0; b < 4; b++) begin expb(0, 3, b); expb(1, 3, b); end
`endif
    wait_drain(60);
    @(negedge clk);
    chk("end_grant", 64'(grant), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
